// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - request/response bundle between the EXE/MEM register and the memory stage
interface mem_stage_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_result;
  logic [31:0] Val_Rm;
  logic [31:0] MEM_result;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
    input  MEM_result, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm,
    output MEM_result, ready
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - multi-cycle data memory stage with wait states and pipeline stall
module mem_stage #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           we_q, we_d;
  logic [31:0]    result_q, result_d;
  logic           ready_o;

  // Contents are deliberately left out of reset
  logic [31:0]    mem [DEPTH];

  logic           req;
  logic           last_wait;
  logic           commit;
  logic [31:0]    offs;
  logic [AW-1:0]  idx;
  logic           unused_offs;

  assign req       = bus.MEM_R_EN | bus.MEM_W_EN;
  assign offs      = bus.ALU_result - BASE_ADDR;
  // Byte offset to word index; upper bits wrap, byte-lane bits are dropped
  assign idx       = offs[AW+1:2];
  assign unused_offs = ^{offs[31:AW+2], offs[1:0]};
  assign last_wait = (state_q == WAIT) && (cnt_q == LAST_CNT);
  // A reset landing mid-access must not let the pending store through
  assign commit    = last_wait && !rst;

  assign bus.ready      = ready_o;
  assign bus.MEM_result = result_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a request seen in DONE belongs to the finished instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT:    if (last_wait) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: stall starts combinationally in the accepting IDLE cycle
  always_comb begin
    ready_o = 1'b1;
    case (state_q)
      IDLE:    ready_o = !req;
      WAIT:    ready_o = 1'b0;
      DONE:    ready_o = 1'b1;
      default: ready_o = 1'b1;
    endcase
  end

  // Capture, wait counting and load-result next-state
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d  = 4'd0;
          addr_d = idx;
          data_d = bus.Val_Rm;
          // Store wins when both enables are set
          we_d   = bus.MEM_W_EN;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (last_wait && !we_q) result_d = mem[addr_q];
      end
      default: ;
    endcase
  end

  // Capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      data_q   <= 32'h0;
      we_q     <= 1'b0;
      result_q <= 32'h0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      result_q <= result_d;
    end
  end

  // Store commit on the edge leaving the last wait cycle
  always_ff @(posedge clk) begin
    if (commit && we_q) mem[addr_q] <= data_q;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001: Parameter WAIT_CYCLES, default 2: access wait states, legal range 1..15.
- REQ-002: Parameter DEPTH, default 64: data memory size in 32-bit words, power of two.
- REQ-003: Parameter BASE_ADDR, default 1024: byte address mapped to word 0.
- REQ-004: Port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-005: Port rst, input, 1: asynchronous, active-high reset.
- REQ-006: Port MEM_R_EN, input, 1: load request from the EXE/MEM pipeline register.
- REQ-007: Port MEM_W_EN, input, 1: store request from the EXE/MEM pipeline register.
- REQ-008: Port ALU_result, input, 32: byte address computed by the execute stage.
- REQ-009: Port Val_Rm, input, 32: store data.
- REQ-010: Port MEM_result, output, 32: registered load data.
- REQ-011: Port ready, output, 1: high means the pipeline may advance; low freezes all upstream pipeline registers.

Function
- REQ-012: The block SHALL contain an FSM with states IDLE, WAIT and DONE, a 4-bit wait counter, and capture registers for address, data and operation.
- REQ-013: In IDLE with MEM_R_EN or MEM_W_EN high, the block SHALL capture the address, data and operation, clear the counter, enter WAIT, and drive ready low in that same cycle (combinational).
- REQ-014: In IDLE with no request, ready SHALL be high, the state SHALL remain IDLE, and MEM_result SHALL hold.
- REQ-015: WAIT SHALL last exactly WAIT_CYCLES cycles, with ready low throughout and the counter incrementing each cycle.
- REQ-016: On the edge leaving the last WAIT cycle, the block SHALL commit a store to memory, or register the load word into MEM_result, and enter DONE.
- REQ-017: DONE SHALL last one cycle with ready high, then return to IDLE unconditionally; a request present in DONE SHALL be ignored because it belongs to the already-completed instruction.
- REQ-018: Total stall SHALL be WAIT_CYCLES+1 cycles of ready low per access; a back-to-back new request is accepted in the IDLE cycle after DONE.
- REQ-019: Word index SHALL be ((ALU_result - BASE_ADDR) >> 2) modulo DEPTH; addresses outside the window wrap, and the low two address bits are ignored.
- REQ-020: With MEM_R_EN and MEM_W_EN both high, the block SHALL perform a store only; MEM_result SHALL remain unchanged.
- REQ-021: Input changes after acceptance, including request deassertion during WAIT, SHALL NOT affect the access; the captured values are used.
- REQ-022: MEM_result SHALL change only on load completion and SHALL hold its value across stores and idle cycles.
- REQ-023: Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by rst.

Reset
- REQ-024: While rst is asserted, the FSM SHALL be IDLE, the counter 0, MEM_result 32'h0, and ready high unless a request is present.
- REQ-025: If rst asserts during WAIT, the pending access SHALL be abandoned with no memory write and no MEM_result update.
- REQ-026: After rst deasserts, the first rising edge with a request present SHALL start a new access per REQ-013.

Verification (WAIT_CYCLES=2, BASE_ADDR=1024)
- REQ-027: Store 32'hDEADBEEF at address 1028, then load from 1028: ready is low for 3 cycles on each access; MEM_result = 32'hDEADBEEF in the DONE cycle of the load.
- REQ-028: Store 32'h1 at address 1024, then load from 1024+4*DEPTH: the address wraps to word 0 and MEM_result = 32'h1.
- REQ-029: MEM_R_EN and MEM_W_EN both high, address 1032, data 32'h55: word 2 = 32'h55 and MEM_result is unchanged from its prior value.
- REQ-030: Store request at 1036 accepted, then ALU_result changed to 1040 and Val_Rm to 0 during WAIT: word 3 receives the originally captured data and word 4 is untouched.
- REQ-031: rst pulsed in the second WAIT cycle of a store of 32'hAA to word 5 that previously held 32'h77: word 5 still reads 32'h77, and MEM_result is 0 until the next load completes.
- REQ-032: Load requests held continuously for 3 instructions: ready pattern is 0,0,0,1 repeating, and exactly three accesses occur.
